// File: rtl/channel_stim_capture_pkg.sv
// Shared types and constants for the channel stimulus/capture block.
package channel_stim_capture_pkg;

    // Run sequencing states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WARMUP,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [15:0] LFSR_MASK     = 16'hB400;
    localparam logic [15:0] SEED_ZERO_SUB = 16'hACE1;

    // One step of the right-shifting Galois LFSR
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_MASK) : (v >> 1);
    endfunction

    // An all-zero seed would lock the LFSR, so it is replaced
    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        return (s == 16'h0000) ? SEED_ZERO_SUB : s;
    endfunction

endpackage

// File: rtl/channel_stim_capture_level_stat_acc.sv
// Per-level count/sum/min/max register bank with an update port and a
// registered read port. A read always returns the pre-update value.
module level_stat_acc #(
    parameter int LEVEL_BITS = 2,
    parameter int VW         = 16,
    parameter int NSAMP_W    = 20,
    parameter int ACC_W      = NSAMP_W + VW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  upd,
    input  logic [LEVEL_BITS-1:0] upd_level,
    input  logic [VW-1:0]         upd_val,
    input  logic [LEVEL_BITS-1:0] rd_level,
    output logic [NSAMP_W-1:0]    rd_cnt,
    output logic [ACC_W-1:0]      rd_sum,
    output logic [VW-1:0]         rd_min,
    output logic [VW-1:0]         rd_max
);
    localparam int NLEV = 2 ** LEVEL_BITS;

    logic [NSAMP_W-1:0] cnt_q [NLEV];
    logic [ACC_W-1:0]   sum_q [NLEV];
    logic [VW-1:0]      min_q [NLEV];
    logic [VW-1:0]      max_q [NLEV];

    // Statistics bank: clear at run start, accumulate on tagged captures
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NLEV; i++) begin
                cnt_q[i] <= '0;
                sum_q[i] <= '0;
                min_q[i] <= '1;
                max_q[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < NLEV; i++) begin
                cnt_q[i] <= '0;
                sum_q[i] <= '0;
                min_q[i] <= '1;
                max_q[i] <= '0;
            end
        end else if (upd) begin
            cnt_q[upd_level] <= cnt_q[upd_level] + NSAMP_W'(1);
            sum_q[upd_level] <= sum_q[upd_level] + ACC_W'(upd_val);
            if (upd_val < min_q[upd_level]) min_q[upd_level] <= upd_val;
            if (upd_val > max_q[upd_level]) max_q[upd_level] <= upd_val;
        end
    end

    // Registered read port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_cnt <= '0;
            rd_sum <= '0;
            rd_min <= '0;
            rd_max <= '0;
        end else begin
            rd_cnt <= cnt_q[rd_level];
            rd_sum <= sum_q[rd_level];
            rd_min <= min_q[rd_level];
            rd_max <= max_q[rd_level];
        end
    end

endmodule

// File: rtl/channel_stim_capture.sv
// Drives pseudo-random cell levels into a channel model, then captures the
// returned retention voltages into per-level statistics once the model
// latency has been absorbed.
//
// state     | meaning
// ----------+-------------------------------------------------------
// ST_IDLE   | waiting for start
// ST_WARMUP | levels issued, returned samples not captured
// ST_RUN    | levels issued with capture tag set
// ST_DRAIN  | no new levels; last tagged samples still in flight
// ST_DONE   | single-cycle done pulse
module channel_stim_capture
    import channel_stim_capture_pkg::*;
#(
    parameter int LEVEL_BITS = 2,
    parameter int VW         = 16,
    parameter int MODEL_LAT  = 4,
    parameter int WARMUP     = 30,
    parameter int NSAMP_W    = 20,
    parameter int ACC_W      = NSAMP_W + VW
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [NSAMP_W-1:0]    sample_count,
    input  logic [15:0]           seed,
    output logic [LEVEL_BITS-1:0] level_out,
    output logic                  level_valid,
    input  logic                  retention_done,
    input  logic [VW-1:0]         vth_in,
    output logic                  busy,
    output logic                  done,
    output logic [NSAMP_W-1:0]    drop_cnt,
    input  logic [LEVEL_BITS-1:0] rd_level,
    output logic [NSAMP_W-1:0]    rd_cnt,
    output logic [ACC_W-1:0]      rd_sum,
    output logic [VW-1:0]         rd_min,
    output logic [VW-1:0]         rd_max
);
    localparam logic [31:0] WARM_LD  = 32'(WARMUP - 1);
    localparam logic [31:0] DRAIN_LD = 32'(MODEL_LAT - 1);

    state_t                state;
    logic [31:0]           timer;
    logic [NSAMP_W-1:0]    n_lat;
    logic [15:0]           lfsr;
    logic [15:0]           lfsr_nxt;
    logic [15:0]           seed_eff;
    logic                  run_start;
    logic [MODEL_LAT-1:0]  tag_pipe;
    logic [LEVEL_BITS-1:0] lvl_pipe [MODEL_LAT];
    logic                  cap_tag;
    logic [LEVEL_BITS-1:0] cap_level;

    assign lfsr_nxt  = lfsr_step(lfsr);
    assign seed_eff  = seed_fix(seed);
    assign run_start = (state == ST_IDLE) && start;
    assign cap_tag   = tag_pipe[MODEL_LAT-1];
    assign cap_level = lvl_pipe[MODEL_LAT-1];

    // Run sequencer: down-counting phase timer, LFSR level issue, status flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            timer       <= '0;
            n_lat       <= '0;
            lfsr        <= SEED_ZERO_SUB;
            level_out   <= '0;
            level_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_lat     <= sample_count;
                        lfsr      <= seed_eff;
                        level_out <= seed_eff[LEVEL_BITS-1:0];
                        busy      <= 1'b1;
                        if (WARMUP != 0) begin
                            state       <= ST_WARMUP;
                            timer       <= WARM_LD;
                            level_valid <= 1'b1;
                        end else if (sample_count != '0) begin
                            state       <= ST_RUN;
                            timer       <= 32'(sample_count) - 32'd1;
                            level_valid <= 1'b1;
                        end else begin
                            state       <= ST_DRAIN;
                            timer       <= DRAIN_LD;
                            level_valid <= 1'b0;
                        end
                    end
                end
                ST_WARMUP: begin
                    if (timer == '0 && n_lat == '0) begin
                        state       <= ST_DRAIN;
                        timer       <= DRAIN_LD;
                        level_valid <= 1'b0;
                    end else begin
                        if (timer == '0) begin
                            state <= ST_RUN;
                            timer <= 32'(n_lat) - 32'd1;
                        end else begin
                            timer <= timer - 32'd1;
                        end
                        lfsr      <= lfsr_nxt;
                        level_out <= lfsr_nxt[LEVEL_BITS-1:0];
                    end
                end
                ST_RUN: begin
                    if (timer == '0) begin
                        state       <= ST_DRAIN;
                        timer       <= DRAIN_LD;
                        level_valid <= 1'b0;
                    end else begin
                        timer     <= timer - 32'd1;
                        lfsr      <= lfsr_nxt;
                        level_out <= lfsr_nxt[LEVEL_BITS-1:0];
                    end
                end
                ST_DRAIN: begin
                    if (timer == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        timer <= timer - 32'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state       <= ST_IDLE;
                    level_valid <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    // Tag/level delay line matching the channel-model latency
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MODEL_LAT; i++) begin
                tag_pipe[i] <= 1'b0;
                lvl_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= level_valid && (state == ST_RUN);
            lvl_pipe[0] <= level_out;
            for (int i = 1; i < MODEL_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
                lvl_pipe[i] <= lvl_pipe[i-1];
            end
        end
    end

    // Count tagged samples the channel model failed to return
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= '0;
        end else if (run_start) begin
            drop_cnt <= '0;
        end else if (cap_tag && !retention_done) begin
            drop_cnt <= drop_cnt + NSAMP_W'(1);
        end
    end

    level_stat_acc #(
        .LEVEL_BITS (LEVEL_BITS),
        .VW         (VW),
        .NSAMP_W    (NSAMP_W),
        .ACC_W      (ACC_W)
    ) u_stat (
        .clk       (clk),
        .reset     (reset),
        .clr       (run_start),
        .upd       (cap_tag && retention_done),
        .upd_level (cap_level),
        .upd_val   (vth_in),
        .rd_level  (rd_level),
        .rd_cnt    (rd_cnt),
        .rd_sum    (rd_sum),
        .rd_min    (rd_min),
        .rd_max    (rd_max)
    );

endmodule

// File: tb/tb_channel_stim_capture.sv
// Directed bench for channel_stim_capture with a latency-matched channel
// model stub and a reference statistics model.
module tb_channel_stim_capture;
    localparam int LEVEL_BITS = 2;
    localparam int VW         = 16;
    localparam int MODEL_LAT  = 4;
    localparam int WARMUP     = 30;
    localparam int NSAMP_W    = 20;
    localparam int ACC_W      = NSAMP_W + VW;

    logic                  clk = 1'b0;
    logic                  reset = 1'b0;
    logic                  start = 1'b0;
    logic [NSAMP_W-1:0]    sample_count = '0;
    logic [15:0]           seed = '0;
    logic [LEVEL_BITS-1:0] level_out;
    logic                  level_valid;
    logic                  retention_done;
    logic [VW-1:0]         vth_in;
    logic                  busy;
    logic                  done;
    logic [NSAMP_W-1:0]    drop_cnt;
    logic [LEVEL_BITS-1:0] rd_level = '0;
    logic [NSAMP_W-1:0]    rd_cnt;
    logic [ACC_W-1:0]      rd_sum;
    logic [VW-1:0]         rd_min;
    logic [VW-1:0]         rd_max;

    int checks = 0;
    int failures = 0;

    int cyc = 0;
    int start_cyc = 0;
    int rel = 0;
    int run_n = 0;
    bit run_active = 0;
    bit drop_en = 0;
    int drop_lo = 0;
    int drop_hi = -1;
    int kval;
    int lv;
    int lvl_err = 0;
    int ref_drop = 0;
    int ref_cnt [4];
    longint ref_sum [4];
    int ref_min [4];
    int ref_max [4];
    logic [15:0] exp_lfsr = 16'h0;
    logic [LEVEL_BITS-1:0] hist [MODEL_LAT+1];
    int done_seen;

    always #5 clk = ~clk;

    channel_stim_capture #(
        .LEVEL_BITS (LEVEL_BITS),
        .VW         (VW),
        .MODEL_LAT  (MODEL_LAT),
        .WARMUP     (WARMUP),
        .NSAMP_W    (NSAMP_W),
        .ACC_W      (ACC_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .sample_count   (sample_count),
        .seed           (seed),
        .level_out      (level_out),
        .level_valid    (level_valid),
        .retention_done (retention_done),
        .vth_in         (vth_in),
        .busy           (busy),
        .done           (done),
        .drop_cnt       (drop_cnt),
        .rd_level       (rd_level),
        .rd_cnt         (rd_cnt),
        .rd_sum         (rd_sum),
        .rd_min         (rd_min),
        .rd_max         (rd_max)
    );

    function automatic logic [15:0] ref_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Channel model stub: returns 1000*level + k, MODEL_LAT cycles after issue
    initial begin
        vth_in = '0;
        retention_done = 1'b1;
        for (int i = 0; i <= MODEL_LAT; i++) hist[i] = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            for (int i = MODEL_LAT; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = level_out;
            rel = cyc - start_cyc;
            kval = (cyc * 37) % 1000;
            vth_in = 16'(1000 * int'(hist[MODEL_LAT]) + kval);
            retention_done = !(drop_en && rel >= drop_lo && rel <= drop_hi);
            if (run_active) begin
                if (rel >= 0 && rel < WARMUP + run_n) begin
                    if (level_out !== exp_lfsr[LEVEL_BITS-1:0] || level_valid !== 1'b1) lvl_err++;
                    exp_lfsr = ref_step(exp_lfsr);
                end
                if (rel >= WARMUP + MODEL_LAT && rel <= WARMUP + run_n + MODEL_LAT - 1) begin
                    lv = int'(hist[MODEL_LAT]);
                    if (retention_done) begin
                        ref_cnt[lv]++;
                        ref_sum[lv] += longint'(vth_in);
                        if (int'(vth_in) < ref_min[lv]) ref_min[lv] = int'(vth_in);
                        if (int'(vth_in) > ref_max[lv]) ref_max[lv] = int'(vth_in);
                    end else begin
                        ref_drop++;
                    end
                end
            end
        end
    end

    task automatic do_start(input logic [15:0] s, input int n);
        @(negedge clk);
        seed = s;
        sample_count = NSAMP_W'(n);
        start = 1'b1;
        start_cyc = cyc + 1;
        run_n = n;
        exp_lfsr = (s == 16'h0) ? 16'hACE1 : s;
        lvl_err = 0;
        ref_drop = 0;
        for (int l = 0; l < 4; l++) begin
            ref_cnt[l] = 0;
            ref_sum[l] = 0;
            ref_min[l] = 65535;
            ref_max[l] = 0;
        end
        run_active = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_rel(input int r);
        for (int i = 0; i < 1000; i++) begin
            if (rel >= r) break;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input string tag, input int exp_rel);
        int got;
        got = -1;
        for (int i = 0; i < 500; i++) begin
            if (done === 1'b1) begin
                got = rel;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_done_at"}, 64'(got), 64'(exp_rel));
        @(negedge clk);
        chk({tag, "_done_1cyc"}, 64'(done), 64'd0);
        chk({tag, "_idle_busy"}, 64'(busy), 64'd0);
        run_active = 1'b0;
    endtask

    task automatic check_stats(input string tag, input int exp_total);
        int tot;
        tot = 0;
        for (int l = 0; l < 4; l++) begin
            @(negedge clk);
            rd_level = LEVEL_BITS'(l);
            @(posedge clk);
            #2;
            chk($sformatf("%s_cnt%0d", tag, l), 64'(rd_cnt), 64'(ref_cnt[l]));
            chk($sformatf("%s_sum%0d", tag, l), 64'(rd_sum), 64'(ref_sum[l]));
            chk($sformatf("%s_min%0d", tag, l), 64'(rd_min), 64'(ref_min[l]));
            chk($sformatf("%s_max%0d", tag, l), 64'(rd_max), 64'(ref_max[l]));
            if (ref_cnt[l] > 0) begin
                chk($sformatf("%s_range%0d", tag, l),
                    64'(int'(rd_min) >= 1000 * l && int'(rd_max) <= 1000 * l + 999), 64'd1);
            end
            tot += int'(rd_cnt);
        end
        chk({tag, "_total"}, 64'(tot), 64'(exp_total));
    endtask

    initial begin
        // reset state
        #13;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valid", 64'(level_valid), 64'd0);
        chk("rst_level", 64'(level_out), 64'd0);
        chk("rst_drop", 64'(drop_cnt), 64'd0);
        chk("rst_rd_cnt", 64'(rd_cnt), 64'd0);
        chk("rst_rd_min", 64'(rd_min), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        rd_level = 2'd2;
        @(posedge clk);
        #2;
        chk("init_rd_min", 64'(rd_min), 64'hFFFF);
        chk("init_rd_max", 64'(rd_max), 64'd0);

        // nominal run, with a start pulse while busy that must be ignored
        do_start(16'h0001, 100);
        chk("r1_busy", 64'(busy), 64'd1);
        wait_rel(50);
        @(negedge clk);
        sample_count = NSAMP_W'(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_rel(WARMUP + 100 + 1);
        chk("r1_drain_valid", 64'(level_valid), 64'd0);
        chk("r1_drain_busy", 64'(busy), 64'd1);
        wait_done("r1", 134);
        chk("r1_levels", 64'(lvl_err), 64'd0);
        chk("r1_drop", 64'(drop_cnt), 64'd0);
        check_stats("r1", 100);

        // 10 dropped captures in the middle of a 50-sample run
        drop_en = 1'b1;
        drop_lo = WARMUP + MODEL_LAT + 5;
        drop_hi = WARMUP + MODEL_LAT + 14;
        do_start(16'h1234, 50);
        wait_done("r2", WARMUP + 50 + MODEL_LAT);
        drop_en = 1'b0;
        chk("r2_levels", 64'(lvl_err), 64'd0);
        chk("r2_drop", 64'(drop_cnt), 64'd10);
        chk("r2_ref_drop", 64'(ref_drop), 64'd10);
        check_stats("r2", 40);

        // zero samples: RUN skipped, statistics stay at their cleared values
        do_start(16'h00FF, 0);
        wait_done("r3", WARMUP + MODEL_LAT);
        chk("r3_drop", 64'(drop_cnt), 64'd0);
        check_stats("r3", 0);

        // zero seed behaves as 16'hACE1
        do_start(16'h0000, 20);
        wait_done("r4", WARMUP + 20 + MODEL_LAT);
        chk("r4_levels", 64'(lvl_err), 64'd0);
        check_stats("r4", 20);

        // reset during RUN
        do_start(16'hBEEF, 100);
        wait_rel(60);
        @(negedge clk);
        reset = 1'b0;
        run_active = 1'b0;
        #1;
        chk("r5_rst_busy", 64'(busy), 64'd0);
        chk("r5_rst_valid", 64'(level_valid), 64'd0);
        chk("r5_rst_level", 64'(level_out), 64'd0);
        chk("r5_rst_drop", 64'(drop_cnt), 64'd0);
        chk("r5_rst_rd_sum", 64'(rd_sum), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        reset = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        chk("r5_no_done", 64'(done_seen), 64'd0);
        do_start(16'h0005, 10);
        wait_done("r6", WARMUP + 10 + MODEL_LAT);
        chk("r6_levels", 64'(lvl_err), 64'd0);
        check_stats("r6", 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/channel_stim_capture.md
CHANNEL_STIM_CAPTURE -- requirements
Module: channel_stim_capture

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  LEVEL_BITS, 2, bits per cell; 2**LEVEL_BITS voltage levels
  VW, 16, width of retention-voltage sample (unsigned)
  MODEL_LAT, 4, cycles from level issue to matching channel-model output (>=1)
  WARMUP, 30, issued-but-not-captured cycles after start
  NSAMP_W, 20, sample-counter width
  ACC_W, NSAMP_W+VW, per-level sum width
REQ-002 Ports, one per line (name  direction  width  meaning):
  clk  in  1  single clock, rising edge
  reset  in  1  asynchronous, active-low reset
  start  in  1  one-cycle pulse, begins a run
  sample_count  in  NSAMP_W  captured samples requested, sampled at start
  seed  in  16  LFSR seed, sampled at start
  level_out  out  LEVEL_BITS  level driven to channel model VoltageLevel
  level_valid  out  1  level_out is part of the current run
  retention_done  in  1  channel-model RetentionDoneFlag
  vth_in  in  VW  channel-model VoltageOutAfterRetention
  busy  out  1  run in progress
  done  out  1  one-cycle pulse at end of run
  drop_cnt  out  NSAMP_W  tagged samples lost because retention_done was low
  rd_level  in  LEVEL_BITS  statistics read select
  rd_cnt  out  NSAMP_W  samples captured for rd_level
  rd_sum  out  ACC_W  sum of captured vth_in for rd_level
  rd_min  out  VW  minimum captured vth_in for rd_level
  rd_max  out  VW  maximum captured vth_in for rd_level

Function
REQ-003 FSM states IDLE, WARMUP, RUN, DRAIN, DONE; start honoured only in IDLE, ignored otherwise.
REQ-004 IDLE + start -> WARMUP; latch sample_count and seed; clear all statistics and drop_cnt in the same edge.
REQ-005 WARMUP lasts exactly WARMUP cycles, then RUN; if WARMUP=0, go directly to RUN.
REQ-006 RUN lasts exactly latched sample_count cycles, then DRAIN; sample_count=0 skips RUN.
REQ-007 DRAIN lasts exactly MODEL_LAT cycles, then DONE; DONE lasts one cycle (done=1), then IDLE.
REQ-008 busy=1 in WARMUP, RUN, DRAIN, DONE; level_valid=1 in WARMUP and RUN only.
REQ-009 LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400); loaded with seed at start; seed 0 replaced by 16'hACE1.
REQ-010 LFSR advances once per cycle while level_valid=1; level_out = LFSR[LEVEL_BITS-1:0]; level_out holds its last value outside WARMUP/RUN.
REQ-011 Each issued level carries a capture tag (1 in RUN, 0 in WARMUP); {tag, level} pass through a MODEL_LAT-deep shift register.
REQ-012 When the delayed tag is 1 and retention_done=1: for the delayed level, cnt+=1, sum+=vth_in, min=min(min,vth_in), max=max(max,vth_in).
REQ-013 When the delayed tag is 1 and retention_done=0: no statistics update; drop_cnt+=1.
REQ-014 Statistics initial values: cnt=0, sum=0, min=all-ones, max=0; ACC_W guarantees no sum overflow; cnt and drop_cnt cannot exceed sample_count.
REQ-015 rd_* outputs registered: value for rd_level presented one cycle after rd_level is sampled; reads allowed in any state.
REQ-016 Statistics update and read of the same level in the same cycle return the pre-update value.

Reset
REQ-017 reset low asynchronously forces: state IDLE, LFSR=16'hACE1, level_out=0, level_valid=0, busy=0, done=0, drop_cnt=0, all statistics to REQ-014 initial values, delay line tags=0, rd_* outputs 0.
REQ-018 reset mid-run aborts the run with no done pulse; first start after reset release behaves as from IDLE.

Structure
REQ-019 Shared package holds the FSM state enumeration, the LFSR mask 16'hB400, and the zero-seed substitute 16'hACE1.
REQ-020 One sub-module, level_stat_acc: per-level cnt/sum/min/max register bank with update port and registered read port.

Verification
REQ-021 seed=16'h0001, WARMUP=30, sample_count=100, retention_done=1, MODEL_LAT=4 -> done at cycle 30+100+4+1 after start; sum of rd_cnt over 4 levels = 100; drop_cnt=0.
REQ-022 Model stub returns vth=1000*level+k delayed by MODEL_LAT -> each level's rd_min/rd_max fall in [1000*level, 1000*level+999]; rd_sum equals reference-model sum.
REQ-023 retention_done low for 10 RUN-aligned cycles, sample_count=50 -> drop_cnt=10, sum of rd_cnt=40.
REQ-024 sample_count=0 -> no statistics change, done pulses WARMUP+MODEL_LAT+1 cycles after start.
REQ-025 seed=0 -> level sequence identical to seed=16'hACE1; start pulsed while busy -> ignored, run length unchanged.
REQ-026 reset asserted in RUN -> all outputs at REQ-017 values immediately, no done pulse; new start completes normally.
